// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a two-entry skid buffer, registered in_ready,
// flush-to-bubble and saturating stall/flush performance counters.
module id_ex_skid_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      NFIELDS   = 4,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h00000013,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NFIELDS*WIDTH-1:0]   in_data,
  input  logic [WIDTH-1:0]           in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NFIELDS*WIDTH-1:0]   out_data,
  output logic [WIDTH-1:0]           out_instr,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int unsigned      DW      = NFIELDS * WIDTH;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    main_data_q, main_data_d;
  logic [WIDTH-1:0] main_instr_q, main_instr_d;
  logic [DW-1:0]    skid_data_q, skid_data_d;
  logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic main_valid;
  logic push;
  logic pop;

  assign main_valid = (state_q != EMPTY);
  assign push       = in_valid & in_ready_q;
  assign pop        = main_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_instr_d = main_instr_q;
    skid_data_d  = skid_data_q;
    skid_instr_d = skid_instr_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    // Counters see pre-edge state, so a flush cycle can still count as a stall.
    if (main_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (flush && main_valid && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    if (flush) begin
      state_d      = EMPTY;
      main_data_d  = '0;
      main_instr_d = '0;
      skid_data_d  = '0;
      skid_instr_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d      = ONE;
            main_data_d  = in_data;
            main_instr_d = in_instr;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_data_d  = in_data;
            main_instr_d = in_instr;
          end else if (push) begin
            state_d      = FULL;
            skid_data_d  = in_data;
            skid_instr_d = in_instr;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d      = ONE;
            main_data_d  = skid_data_q;
            main_instr_d = skid_instr_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Ready is precomputed from the next state so it needs no path from out_ready.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_data_q  <= '0;
      main_instr_q <= '0;
      skid_data_q  <= '0;
      skid_instr_q <= '0;
      in_ready_q   <= 1'b1;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_instr_q <= main_instr_d;
      skid_data_q  <= skid_data_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data_q;
  assign out_instr = main_valid ? main_instr_q : NOP_INSTR;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: hand-derived vector table, corner sequences and a
// queue-based reference model driven by random traffic.
module tb_id_ex_skid_reg;

  localparam int unsigned W   = 32;
  localparam int unsigned NF  = 4;
  localparam int unsigned CW  = 4;
  localparam int          MAXC = (1 << CW) - 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  in_data = '0;
  logic [31:0]   in_instr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  out_data;
  logic [31:0]   out_instr;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  id_ex_skid_reg #(
    .WIDTH    (W),
    .NFIELDS  (NF),
    .NOP_INSTR(NOP),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_instr(out_instr),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [127:0] data_of(input logic [31:0] i);
    return {i ^ 32'hCAFE0000, i + 32'd8, i + 32'd4, i};
  endfunction

  // ---------------- reference model: FIFO of at most two entries ----------------
  typedef struct {
    logic [127:0] d;
    logic [31:0]  i;
  } ent_t;

  ent_t         m_q[$];
  logic [127:0] m_last;
  int           m_stall;
  int           m_flush;

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_tick();
    bit           push, pop, stall_c, flush_c, fl;
    ent_t         e;
    push    = in_valid && (m_q.size() < 2);
    pop     = (m_q.size() > 0) && out_ready;
    stall_c = (m_q.size() > 0) && !out_ready;
    flush_c = flush && (m_q.size() > 0);
    fl      = flush;
    e.d     = in_data;
    e.i     = in_instr;
    @(posedge clk);
    #1;
    if (stall_c && m_stall < MAXC) m_stall++;
    if (flush_c && m_flush < MAXC) m_flush++;
    if (fl) begin
      m_q.delete();
      m_last = '0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(e);
      if (m_q.size() > 0) m_last = m_q[0].d;
    end
  endtask

  task automatic model_check(input string tag);
    bit nonempty;
    nonempty = (m_q.size() > 0);
    chk({tag, "_out_valid"}, out_valid, nonempty);
    chk({tag, "_in_ready"}, in_ready, m_q.size() < 2);
    chk({tag, "_out_instr"}, out_instr, nonempty ? m_q[0].i : NOP);
    chk({tag, "_out_data"}, out_data, nonempty ? m_q[0].d : m_last);
    chk({tag, "_stall_cnt"}, stall_cnt, m_stall);
    chk({tag, "_flush_cnt"}, flush_cnt, m_flush);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_instr"}, out_instr, NOP);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
    chk({tag, "_flush_cnt"}, flush_cnt, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] instr;
    logic        ov;
    logic [31:0] oi;
    logic [31:0] dsrc;   // instr whose data pattern is expected; 0 means all-zero data
    logic        ir;
    int          st, fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic iv, ordy, fl, input logic [31:0] instr,
                              input logic ov, input logic [31:0] oi, input logic [31:0] dsrc,
                              input logic ir, input int st, fc);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.instr = instr;
    v.ov = ov; v.oi = oi; v.dsrc = dsrc; v.ir = ir; v.st = st; v.fc = fc;
    return v;
  endfunction

  localparam logic [31:0] I1 = 32'h00500093, I2 = 32'h00A00113, I3 = 32'h002081B3;
  localparam logic [31:0] IA = 32'h00100093, IB = 32'h00200113, IC = 32'h00300193;
  localparam logic [31:0] ID = 32'h00400213, IE = 32'h00500293;

  initial begin
    // streaming
    tbl.push_back(mk(1, 1, 0, I1, 1, I1,  I1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, I2, 1, I2,  I2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, I3, 1, I3,  I3, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, NOP, I3, 1, 0, 0));
    // back-pressure: A held, B into skid, C refused until drain
    tbl.push_back(mk(1, 1, 0, IA, 1, IA,  IA, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, IB, 1, IA,  IA, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, IC, 1, IA,  IA, 0, 2, 0));
    tbl.push_back(mk(1, 0, 0, IC, 1, IA,  IA, 0, 3, 0));
    tbl.push_back(mk(1, 1, 0, IC, 1, IB,  IB, 1, 3, 0));
    tbl.push_back(mk(1, 1, 0, IC, 1, IC,  IC, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1, IC,  IC, 1, 4, 0));
    // fill to FULL, then flush with a simultaneous push, then idle flush
    tbl.push_back(mk(1, 0, 0, ID, 1, IC,  IC, 0, 5, 0));
    tbl.push_back(mk(1, 0, 1, IE, 0, NOP, 0,  1, 6, 1));
    tbl.push_back(mk(0, 0, 1, 0,  0, NOP, 0,  1, 6, 1));

    // reset with random inputs, then release
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom); flush = 1'($urandom);
      in_instr = $urandom; in_data = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      check_reset_vals($sformatf("rst%0d", c));
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("rst_rel");

    for (int k = 0; k < tbl.size(); k++) begin
      in_valid  = tbl[k].iv;
      out_ready = tbl[k].ordy;
      flush     = tbl[k].fl;
      in_instr  = tbl[k].instr;
      in_data   = data_of(tbl[k].instr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", k), out_valid, tbl[k].ov);
      chk($sformatf("v%0d_out_instr", k), out_instr, tbl[k].oi);
      chk($sformatf("v%0d_out_data", k), out_data,
          (tbl[k].dsrc == 0) ? 128'd0 : data_of(tbl[k].dsrc));
      chk($sformatf("v%0d_in_ready", k), in_ready, tbl[k].ir);
      chk($sformatf("v%0d_stall_cnt", k), stall_cnt, tbl[k].st);
      chk($sformatf("v%0d_flush_cnt", k), flush_cnt, tbl[k].fc);
    end

    // stall saturation and asynchronous reset mid-stall
    do_reset();
    in_valid = 1'b1; in_instr = IA; in_data = data_of(IA); out_ready = 1'b0;
    model_tick();
    model_check("sat_load");
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      model_tick();
      model_check($sformatf("sat%0d", c));
    end
    chk("stall_saturated", stall_cnt, 15);
    rst_n = 1'b0;
    #2;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized traffic against the queue model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(15) == 0);
      in_instr  = $urandom;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      model_tick();
      model_check($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
